// File: rtl/mips_pkg.sv
// Shared architectural constants for the register file and its address decoders.
package mips_pkg;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned COUNT_W    = 5;
endpackage

// File: rtl/decoder4to16.sv
// Register address to one-hot select, shared by the write and reserve paths.
module decoder4to16
    import mips_pkg::NUM_REGS, mips_pkg::REG_ADDR_W;
(
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [NUM_REGS-1:0]   onehot_c
);

    always_comb begin
        onehot_c       = '0;
        onehot_c[addr] = 1'b1;
    end

endmodule

// File: rtl/register_bank_16x32.sv
// 16x32 register bank with byte-lane writes, busy scoreboard and pending-write counter.
module register_bank_16x32
    import mips_pkg::NUM_REGS, mips_pkg::REG_ADDR_W, mips_pkg::BYTE_LANES, mips_pkg::COUNT_W;
#(
    parameter int unsigned DATA_W   = 32,
    parameter bit          ZERO_REG = 1'b1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic [REG_ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0]     writeData,
    input  logic [BYTE_LANES-1:0] byteEn,
    input  logic                  reserve,
    input  logic [REG_ADDR_W-1:0] reserveAddr,
    input  logic [REG_ADDR_W-1:0] srcA,
    input  logic [REG_ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0]     reg0,
    output logic [DATA_W-1:0]     reg1,
    output logic [DATA_W-1:0]     reg2,
    output logic [DATA_W-1:0]     reg3,
    output logic [DATA_W-1:0]     reg4,
    output logic [DATA_W-1:0]     reg5,
    output logic [DATA_W-1:0]     reg6,
    output logic [DATA_W-1:0]     reg7,
    output logic [DATA_W-1:0]     reg8,
    output logic [DATA_W-1:0]     reg9,
    output logic [DATA_W-1:0]     reg10,
    output logic [DATA_W-1:0]     reg11,
    output logic [DATA_W-1:0]     reg12,
    output logic [DATA_W-1:0]     reg13,
    output logic [DATA_W-1:0]     reg14,
    output logic [DATA_W-1:0]     reg15,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  stall,
    output logic [COUNT_W-1:0]    pendingCount
);

    localparam int unsigned LANE_W = DATA_W / BYTE_LANES;

    logic [NUM_REGS-1:0] wr_onehot;
    logic [NUM_REGS-1:0] rs_onehot;
    logic [NUM_REGS-1:0] zero_mask;
    logic [NUM_REGS-1:0] wr_vec;
    logic [NUM_REGS-1:0] rs_vec;
    logic                set_new;
    logic                clr_old;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    decoder4to16 u_wr_dec (
        .addr     (writeAddr),
        .onehot_c (wr_onehot)
    );

    decoder4to16 u_rs_dec (
        .addr     (reserveAddr),
        .onehot_c (rs_onehot)
    );

    // Register 0 is hardwired when ZERO_REG: its writes and reservations never land.
    assign zero_mask = ZERO_REG ? NUM_REGS'(1) : '0;
    assign wr_vec    = regWrite ? (wr_onehot & ~zero_mask) : '0;
    assign rs_vec    = reserve  ? (rs_onehot & ~zero_mask) : '0;

    // Counter deltas: a reserve on the written register keeps it busy, so no decrement.
    assign set_new = |(rs_vec & ~busy);
    assign clr_old = |(wr_vec & busy & ~rs_vec);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs[r] <= '0;
            end else if (wr_vec[r]) begin
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (byteEn[l]) begin
                        regs[r][l*LANE_W +: LANE_W] <= writeData[l*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= '0;
            pendingCount <= '0;
        end else begin
            busy         <= (busy & ~wr_vec) | rs_vec;
            pendingCount <= pendingCount + COUNT_W'(set_new) - COUNT_W'(clr_old);
        end
    end

    assign stall = busy[srcA] | busy[srcB];

    assign reg0  = regs[0];
    assign reg1  = regs[1];
    assign reg2  = regs[2];
    assign reg3  = regs[3];
    assign reg4  = regs[4];
    assign reg5  = regs[5];
    assign reg6  = regs[6];
    assign reg7  = regs[7];
    assign reg8  = regs[8];
    assign reg9  = regs[9];
    assign reg10 = regs[10];
    assign reg11 = regs[11];
    assign reg12 = regs[12];
    assign reg13 = regs[13];
    assign reg14 = regs[14];
    assign reg15 = regs[15];

endmodule

// File: tb/tb_register_bank_16x32.sv
// Random and directed stimulus for register_bank_16x32 against an array-based reference model.
module tb_register_bank_16x32;

    localparam bit ZR = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [3:0]  writeAddr;
    logic [31:0] writeData;
    logic [3:0]  byteEn;
    logic        reserve;
    logic [3:0]  reserveAddr;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [31:0] dut_reg [16];
    logic [15:0] busy;
    logic        stall;
    logic [4:0]  pendingCount;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_reg [16];
    logic [15:0] m_busy;

    always #5 clk = ~clk;

    register_bank_16x32 #(.DATA_W(32), .ZERO_REG(ZR)) dut (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
        .writeData(writeData), .byteEn(byteEn), .reserve(reserve),
        .reserveAddr(reserveAddr), .srcA(srcA), .srcB(srcB),
        .reg0(dut_reg[0]),   .reg1(dut_reg[1]),   .reg2(dut_reg[2]),   .reg3(dut_reg[3]),
        .reg4(dut_reg[4]),   .reg5(dut_reg[5]),   .reg6(dut_reg[6]),   .reg7(dut_reg[7]),
        .reg8(dut_reg[8]),   .reg9(dut_reg[9]),   .reg10(dut_reg[10]), .reg11(dut_reg[11]),
        .reg12(dut_reg[12]), .reg13(dut_reg[13]), .reg14(dut_reg[14]), .reg15(dut_reg[15]),
        .busy(busy), .stall(stall), .pendingCount(pendingCount)
    );

    // Reference model: per-register data array and busy set; count is derived from the set.
    always @(posedge clk or posedge reset) begin
        logic [15:0] nb;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_reg[i] = '0;
            m_busy = '0;
        end else begin
            nb = m_busy;
            if (regWrite && !(ZR && writeAddr == 4'd0)) begin
                for (int l = 0; l < 4; l++)
                    if (byteEn[l]) m_reg[writeAddr][8*l +: 8] = writeData[8*l +: 8];
                nb[writeAddr] = 1'b0;
            end
            if (reserve && !(ZR && reserveAddr == 4'd0)) nb[reserveAddr] = 1'b1;
            m_busy = nb;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) check($sformatf("model reg%0d", i), dut_reg[i], m_reg[i]);
        check("model busy", 32'(busy), 32'(m_busy));
        check("model pendingCount", 32'(pendingCount), 32'($countones(m_busy)));
        check("model stall", 32'(stall), 32'(m_busy[srcA] | m_busy[srcB]));
    end

    task automatic idle();
        regWrite = 1'b0;
        reserve  = 1'b0;
        byteEn   = 4'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        regWrite  = 1'b1;
        writeAddr = a;
        writeData = d;
        byteEn    = be;
    endtask

    task automatic rsv(input logic [3:0] a);
        reserve     = 1'b1;
        reserveAddr = a;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        writeAddr = '0; writeData = '0; reserveAddr = '0; srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset count", 32'(pendingCount), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        check("reset reg5", dut_reg[5], 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        wr(4'd5, 32'hDEADBEEF, 4'hF); cyc();
        @(negedge clk);
        check("full write reg5", dut_reg[5], 32'hDEADBEEF);
        check("untouched reg4", dut_reg[4], 32'h0);

        #1 wr(4'd7, 32'h11223344, 4'hF); cyc();
        wr(4'd7, 32'hAABBCCDD, 4'b0101); cyc();
        @(negedge clk);
        check("lane write reg7", dut_reg[7], 32'h11BB33DD);

        #1 wr(4'd0, 32'hFFFFFFFF, 4'hF); cyc();
        rsv(4'd0); cyc();
        @(negedge clk);
        check("zero reg0", dut_reg[0], 32'h0);
        check("zero busy", 32'(busy), 32'h0);
        check("zero count", 32'(pendingCount), 32'h0);

        #1 rsv(4'd3); cyc();
        rsv(4'd9); cyc();
        srcA = 4'd9;
        @(negedge clk);
        check("two reserves count", 32'(pendingCount), 32'd2);
        check("stall on 9", 32'(stall), 32'd1);
        #1 wr(4'd9, 32'h00000099, 4'hF); cyc();
        @(negedge clk);
        check("busy9 cleared", 32'(busy[9]), 32'd0);
        check("count after wb", 32'(pendingCount), 32'd1);
        check("stall released", 32'(stall), 32'd0);

        #1 rsv(4'd4); wr(4'd4, 32'h12345678, 4'hF); cyc();
        @(negedge clk);
        check("same-addr reg4", dut_reg[4], 32'h12345678);
        check("same-addr busy4", 32'(busy[4]), 32'd1);
        check("same-addr count", 32'(pendingCount), 32'd2);

        #1 wr(4'd3, 32'hFFFFFFFF, 4'h0); cyc();
        @(negedge clk);
        check("cancel busy3", 32'(busy[3]), 32'd0);
        check("cancel count", 32'(pendingCount), 32'd1);
        check("cancel reg3 data", dut_reg[3], 32'h0);

        #1 rsv(4'd2); cyc();
        rsv(4'd6); wr(4'd11, 32'h0BADF00D, 4'hF);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", 32'(busy), 32'h0);
        check("async reset count", 32'(pendingCount), 32'h0);
        @(posedge clk); #1 reset = 1'b0; idle();
        @(negedge clk);
        check("flight write dropped", dut_reg[11], 32'h0);
        #1 wr(4'd2, 32'hCAFEF00D, 4'hF); cyc();
        @(negedge clk);
        check("late wb reg2", dut_reg[2], 32'hCAFEF00D);
        check("late wb busy", 32'(busy), 32'h0);
        check("late wb count", 32'(pendingCount), 32'h0);

        for (int n = 0; n < 800; n++) begin
            #1;
            reset       = ($urandom_range(0, 149) == 0);
            regWrite    = $urandom_range(0, 2) == 0;
            writeAddr   = 4'($urandom_range(0, 15));
            writeData   = $urandom;
            byteEn      = 4'($urandom_range(0, 15));
            reserve     = $urandom_range(0, 2) == 0;
            reserveAddr = ($urandom_range(0, 3) == 0) ? writeAddr : 4'($urandom_range(0, 15));
            srcA        = 4'($urandom_range(0, 15));
            srcB        = 4'($urandom_range(0, 15));
            @(posedge clk);
        end
        #1 reset = 1'b0; idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
